// File: rtl/execute_cc_stage_if.sv
// Execute-stage bundle: E-stage inputs and CC/stall controls in, CC, Cnd and E->M register out.
// The testbench drives through master; execute_cc_stage consumes through slave.
interface execute_cc_stage_if #(
    parameter int unsigned BIT_WISE = 64
);
    logic                e_valid;
    logic [3:0]          e_icode;
    logic [3:0]          e_ifun;
    logic [BIT_WISE-1:0] e_valE;
    logic [BIT_WISE-1:0] e_valA;
    logic [3:0]          e_dstE;
    logic [3:0]          e_dstM;
    logic [3:0]          alu_cc;
    logic                set_cc;
    logic                cc_block;
    logic                m_stall;
    logic                m_bubble;

    logic [3:0]          cc_q;
    logic                e_Cnd;
    logic                M_valid;
    logic [3:0]          M_icode;
    logic                M_Cnd;
    logic [BIT_WISE-1:0] M_valE;
    logic [BIT_WISE-1:0] M_valA;
    logic [3:0]          M_dstE;
    logic [3:0]          M_dstM;

    modport master (
        output e_valid, e_icode, e_ifun, e_valE, e_valA, e_dstE, e_dstM,
        output alu_cc, set_cc, cc_block, m_stall, m_bubble,
        input  cc_q, e_Cnd, M_valid, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
    );

    modport slave (
        input  e_valid, e_icode, e_ifun, e_valE, e_valA, e_dstE, e_dstM,
        input  alu_cc, set_cc, cc_block, m_stall, m_bubble,
        output cc_q, e_Cnd, M_valid, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
    );
endinterface

// File: rtl/execute_cc_stage.sv
// Execute-stage back end: condition-code register, jXX/cmovXX condition evaluation,
// cmov destination squash and the E->M pipeline register with stall/bubble control.
module execute_cc_stage #(
    parameter int unsigned BIT_WISE = 64,
    parameter logic [3:0]  RNONE    = 4'hF,
    parameter logic [3:0]  I_NOP    = 4'h1,
    parameter logic [3:0]  I_RRMOVQ = 4'h2,
    parameter logic [3:0]  CC_RESET = 4'b0001
) (
    input logic               clk,
    input logic               rst,
    execute_cc_stage_if.slave bus
);

    logic [3:0]          cc_reg_q, cc_reg_d;
    logic                cnd;
    logic                lt;
    logic [3:0]          dst_e_eff;

    logic                m_valid_q, m_valid_d;
    logic [3:0]          m_icode_q, m_icode_d;
    logic                m_cnd_q, m_cnd_d;
    logic [BIT_WISE-1:0] m_val_e_q, m_val_e_d;
    logic [BIT_WISE-1:0] m_val_a_q, m_val_a_d;
    logic [3:0]          m_dst_e_q, m_dst_e_d;
    logic [3:0]          m_dst_m_q, m_dst_m_d;

    // Cnd comes from the registered CC only, so an OPq in the previous cycle is already visible.
    always_comb begin
        lt  = cc_reg_q[1] ^ cc_reg_q[2];
        cnd = 1'b0;
        case (bus.e_ifun)
            4'd0:    cnd = 1'b1;
            4'd1:    cnd = lt | cc_reg_q[0];
            4'd2:    cnd = lt;
            4'd3:    cnd = cc_reg_q[0];
            4'd4:    cnd = ~cc_reg_q[0];
            4'd5:    cnd = ~lt;
            4'd6:    cnd = ~lt & ~cc_reg_q[0];
            4'd7:    cnd = cc_reg_q[3];
            default: cnd = 1'b0;
        endcase
    end

    always_comb begin
        dst_e_eff = bus.e_dstE;
        if (bus.e_icode == I_RRMOVQ && !cnd) begin
            dst_e_eff = RNONE;
        end
    end

    always_comb begin
        cc_reg_d = cc_reg_q;
        if (bus.set_cc && bus.e_valid && !bus.cc_block && !bus.m_stall) begin
            cc_reg_d = bus.alu_cc;
        end
    end

    always_comb begin
        m_valid_d = m_valid_q;
        m_icode_d = m_icode_q;
        m_cnd_d   = m_cnd_q;
        m_val_e_d = m_val_e_q;
        m_val_a_d = m_val_a_q;
        m_dst_e_d = m_dst_e_q;
        m_dst_m_d = m_dst_m_q;
        if (bus.m_stall) begin
            // hold
        end else if (bus.m_bubble) begin
            m_valid_d = 1'b0;
            m_icode_d = I_NOP;
            m_cnd_d   = 1'b0;
            m_val_e_d = '0;
            m_val_a_d = '0;
            m_dst_e_d = RNONE;
            m_dst_m_d = RNONE;
        end else begin
            m_valid_d = bus.e_valid;
            m_icode_d = bus.e_icode;
            m_cnd_d   = cnd;
            m_val_e_d = bus.e_valE;
            m_val_a_d = bus.e_valA;
            m_dst_e_d = dst_e_eff;
            m_dst_m_d = bus.e_dstM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cc_reg_q  <= CC_RESET;
            m_valid_q <= 1'b0;
            m_icode_q <= I_NOP;
            m_cnd_q   <= 1'b0;
            m_val_e_q <= '0;
            m_val_a_q <= '0;
            m_dst_e_q <= RNONE;
            m_dst_m_q <= RNONE;
        end else begin
            cc_reg_q  <= cc_reg_d;
            m_valid_q <= m_valid_d;
            m_icode_q <= m_icode_d;
            m_cnd_q   <= m_cnd_d;
            m_val_e_q <= m_val_e_d;
            m_val_a_q <= m_val_a_d;
            m_dst_e_q <= m_dst_e_d;
            m_dst_m_q <= m_dst_m_d;
        end
    end

    assign bus.cc_q    = cc_reg_q;
    assign bus.e_Cnd   = cnd;
    assign bus.M_valid = m_valid_q;
    assign bus.M_icode = m_icode_q;
    assign bus.M_Cnd   = m_cnd_q;
    assign bus.M_valE  = m_val_e_q;
    assign bus.M_valA  = m_val_a_q;
    assign bus.M_dstE  = m_dst_e_q;
    assign bus.M_dstM  = m_dst_m_q;

endmodule

// File: tb/tb_execute_cc_stage.sv
// Randomised and directed bench for execute_cc_stage against a flag-level behavioural model.
module tb_execute_cc_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;

    execute_cc_stage_if #(.BIT_WISE(64)) bus ();

    execute_cc_stage #(.BIT_WISE(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          valid;
        logic [3:0]  icode;
        bit          cnd;
        logic [63:0] val_e;
        logic [63:0] val_a;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
    } mstage_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [3:0]  mdl_cc;
    mstage_t     mdl_m;
    mstage_t     reset_m = '{valid: 0, icode: 4'h1, cnd: 0, val_e: '0, val_a: '0,
                             dst_e: 4'hF, dst_m: 4'hF};

    // Condition table expressed on named flags.
    function automatic bit exp_cnd(input logic [3:0] cc, input logic [3:0] ifun);
        bit zf, sf, of, cf, less;
        zf   = cc[0];
        sf   = cc[1];
        of   = cc[2];
        cf   = cc[3];
        less = (sf != of);
        case (ifun)
            4'd0:    return 1'b1;
            4'd1:    return less || zf;
            4'd2:    return less;
            4'd3:    return zf;
            4'd4:    return !zf;
            4'd5:    return !less;
            4'd6:    return !less && !zf;
            4'd7:    return cf;
            default: return 1'b0;
        endcase
    endfunction

    // Advance the model with the inputs now presented, then clock the DUT.
    task automatic tick();
        mstage_t nxt;
        logic [3:0] nxt_cc;
        bit c;
        nxt    = mdl_m;
        nxt_cc = mdl_cc;
        c      = exp_cnd(mdl_cc, bus.e_ifun);
        if (rst) begin
            nxt_cc = 4'b0001;
            nxt    = reset_m;
        end else if (!bus.m_stall) begin
            if (bus.set_cc && bus.e_valid && !bus.cc_block) nxt_cc = bus.alu_cc;
            if (bus.m_bubble) begin
                nxt = reset_m;
            end else begin
                nxt.valid = bus.e_valid;
                nxt.icode = bus.e_icode;
                nxt.cnd   = c;
                nxt.val_e = bus.e_valE;
                nxt.val_a = bus.e_valA;
                nxt.dst_e = (bus.e_icode == 4'h2 && !c) ? 4'hF : bus.e_dstE;
                nxt.dst_m = bus.e_dstM;
            end
        end
        mdl_cc = nxt_cc;
        mdl_m  = nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.e_valid  = 0;
        bus.e_icode  = 4'h0;
        bus.e_ifun   = 4'h0;
        bus.e_valE   = '0;
        bus.e_valA   = '0;
        bus.e_dstE   = 4'hF;
        bus.e_dstM   = 4'hF;
        bus.alu_cc   = 4'h0;
        bus.set_cc   = 0;
        bus.cc_block = 0;
        bus.m_stall  = 0;
        bus.m_bubble = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        bus.e_ifun = 4'd1;
        #1;
        n_checks++;
        if (bus.cc_q !== 4'b0001) begin
            n_errors++;
            $display("FAIL reset_cc got %h want 1", bus.cc_q);
        end
        n_checks++;
        if (bus.e_Cnd !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_cnd_le got %b want 1", bus.e_Cnd);
        end
        n_checks++;
        if ({bus.M_valid, bus.M_icode, bus.M_dstE, bus.M_dstM} !== {1'b0, 4'h1, 4'hF, 4'hF}) begin
            n_errors++;
            $display("FAIL reset_m got v=%b i=%h dE=%h dM=%h want v=0 i=1 dE=f dM=f",
                     bus.M_valid, bus.M_icode, bus.M_dstE, bus.M_dstM);
        end
        n_checks++;
        if ({bus.M_Cnd, bus.M_valE, bus.M_valA} !== {1'b0, 64'h0, 64'h0}) begin
            n_errors++;
            $display("FAIL reset_m_data got c=%b e=%h a=%h want zeros",
                     bus.M_Cnd, bus.M_valE, bus.M_valA);
        end
    endtask

    task automatic test_cc_jxx();
        idle_inputs();
        bus.alu_cc  = 4'b0010;
        bus.set_cc  = 1;
        bus.e_valid = 1;
        bus.e_icode = 4'h6;
        tick();
        bus.set_cc  = 0;
        bus.e_icode = 4'h7;
        bus.e_ifun  = 4'd2;
        #1;
        n_checks++;
        if (bus.cc_q !== 4'b0010) begin
            n_errors++;
            $display("FAIL cc_write got %h want 2", bus.cc_q);
        end
        n_checks++;
        if (bus.e_Cnd !== 1'b1) begin
            n_errors++;
            $display("FAIL jl_taken got %b want 1", bus.e_Cnd);
        end
        bus.e_ifun = 4'd5;
        #1;
        n_checks++;
        if (bus.e_Cnd !== 1'b0) begin
            n_errors++;
            $display("FAIL jge_not_taken got %b want 0", bus.e_Cnd);
        end
        tick();
    endtask

    task automatic test_cmov();
        idle_inputs();
        bus.alu_cc  = 4'b0110;
        bus.set_cc  = 1;
        bus.e_valid = 1;
        tick();
        bus.set_cc  = 0;
        bus.e_icode = 4'h2;
        bus.e_ifun  = 4'd6;
        bus.e_dstE  = 4'h3;
        bus.e_valE  = 64'h55;
        #1;
        n_checks++;
        if (bus.e_Cnd !== 1'b1) begin
            n_errors++;
            $display("FAIL cmovg_cnd got %b want 1", bus.e_Cnd);
        end
        tick();
        n_checks++;
        if ({bus.M_dstE, bus.M_valE, bus.M_Cnd} !== {4'h3, 64'h55, 1'b1}) begin
            n_errors++;
            $display("FAIL cmov_taken got dE=%h e=%h c=%b want dE=3 e=55 c=1",
                     bus.M_dstE, bus.M_valE, bus.M_Cnd);
        end
        bus.e_ifun = 4'd3;
        tick();
        n_checks++;
        if ({bus.M_dstE, bus.M_Cnd} !== {4'hF, 1'b0}) begin
            n_errors++;
            $display("FAIL cmov_squash got dE=%h c=%b want dE=f c=0", bus.M_dstE, bus.M_Cnd);
        end
        bus.e_ifun = 4'd0;
        tick();
        n_checks++;
        if (bus.M_dstE !== 4'h3) begin
            n_errors++;
            $display("FAIL rrmovq_kept got dE=%h want 3", bus.M_dstE);
        end
    endtask

    task automatic test_cc_block();
        idle_inputs();
        bus.e_valid  = 1;
        bus.set_cc   = 1;
        bus.alu_cc   = 4'b1000;
        bus.cc_block = 1;
        tick();
        n_checks++;
        if (bus.cc_q !== 4'b0110) begin
            n_errors++;
            $display("FAIL cc_block got %h want 6", bus.cc_q);
        end
        bus.cc_block = 0;
        bus.m_stall  = 1;
        tick();
        n_checks++;
        if (bus.cc_q !== 4'b0110) begin
            n_errors++;
            $display("FAIL cc_stall got %h want 6", bus.cc_q);
        end
        bus.m_stall = 0;
        tick();
        bus.set_cc = 0;
        bus.e_ifun = 4'd7;
        #1;
        n_checks++;
        if (bus.cc_q !== 4'b1000 || bus.e_Cnd !== 1'b1) begin
            n_errors++;
            $display("FAIL cc_release got cc=%h cnd=%b want cc=8 cnd=1", bus.cc_q, bus.e_Cnd);
        end
    endtask

    task automatic test_stall_bubble();
        idle_inputs();
        bus.e_valid = 1;
        bus.e_icode = 4'h6;
        bus.e_valE  = 64'hDEAD;
        bus.e_valA  = 64'h1234;
        bus.e_dstE  = 4'h2;
        bus.e_dstM  = 4'h5;
        tick();
        bus.e_valE   = 64'hBEEF;
        bus.e_dstE   = 4'h7;
        bus.m_stall  = 1;
        bus.m_bubble = 1;
        tick();
        tick();
        n_checks++;
        if ({bus.M_valid, bus.M_icode, bus.M_valE, bus.M_valA, bus.M_dstE, bus.M_dstM} !==
            {1'b1, 4'h6, 64'hDEAD, 64'h1234, 4'h2, 4'h5}) begin
            n_errors++;
            $display("FAIL stall_over_bubble got v=%b i=%h e=%h dE=%h want v=1 i=6 e=dead dE=2",
                     bus.M_valid, bus.M_icode, bus.M_valE, bus.M_dstE);
        end
        bus.m_stall = 0;
        tick();
        n_checks++;
        if ({bus.M_valid, bus.M_icode, bus.M_dstE, bus.M_dstM, bus.M_valE} !==
            {1'b0, 4'h1, 4'hF, 4'hF, 64'h0}) begin
            n_errors++;
            $display("FAIL bubble got v=%b i=%h dE=%h dM=%h e=%h want v=0 i=1 dE=f dM=f e=0",
                     bus.M_valid, bus.M_icode, bus.M_dstE, bus.M_dstM, bus.M_valE);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] ccs [4];
        ccs[0] = 4'h0; ccs[1] = 4'hF; ccs[2] = 4'h6; ccs[3] = 4'h9;
        idle_inputs();
        bus.e_valid = 1;
        bus.e_valE  = 64'hABCD;
        bus.e_dstE  = 4'h4;
        tick();
        bus.set_cc  = 1;
        bus.alu_cc  = 4'hE;
        bus.m_stall = 1;
        rst = 1;
        tick();
        rst = 0;
        n_checks++;
        if (bus.cc_q !== 4'b0001 ||
            {bus.M_valid, bus.M_icode, bus.M_Cnd, bus.M_valE, bus.M_valA, bus.M_dstE,
             bus.M_dstM} !== {1'b0, 4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF}) begin
            n_errors++;
            $display("FAIL reset_mid got cc=%h v=%b i=%h e=%h dE=%h",
                     bus.cc_q, bus.M_valid, bus.M_icode, bus.M_valE, bus.M_dstE);
        end
        bus.m_stall = 0;
        foreach (ccs[k]) begin
            bus.set_cc = 1;
            bus.alu_cc = ccs[k];
            tick();
            bus.set_cc = 0;
            for (int f = 8; f < 16; f++) begin
                bus.e_ifun = 4'(f);
                #1;
                n_checks++;
                if (bus.e_Cnd !== 1'b0) begin
                    n_errors++;
                    $display("FAIL ifun_hi cc=%h ifun=%0d got %b want 0", bus.cc_q, f, bus.e_Cnd);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst          = ($urandom_range(0, 39) == 0);
            bus.e_valid  = $urandom_range(0, 3) != 0;
            bus.e_icode  = ($urandom_range(0, 1) != 0) ? 4'h2 : 4'($urandom);
            bus.e_ifun   = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 7)) : 4'($urandom);
            bus.e_valE   = {$urandom, $urandom};
            bus.e_valA   = {$urandom, $urandom};
            bus.e_dstE   = 4'($urandom);
            bus.e_dstM   = 4'($urandom);
            bus.alu_cc   = 4'($urandom);
            bus.set_cc   = $urandom_range(0, 1) != 0;
            bus.cc_block = $urandom_range(0, 4) == 0;
            bus.m_stall  = $urandom_range(0, 4) == 0;
            bus.m_bubble = $urandom_range(0, 4) == 0;
            #1;
            n_checks++;
            if (bus.e_Cnd !== exp_cnd(mdl_cc, bus.e_ifun)) begin
                n_errors++;
                $display("FAIL rand_cnd n=%0d cc=%h ifun=%h got %b want %b",
                         n, mdl_cc, bus.e_ifun, bus.e_Cnd, exp_cnd(mdl_cc, bus.e_ifun));
            end
            tick();
            n_checks++;
            if (bus.cc_q !== mdl_cc) begin
                n_errors++;
                $display("FAIL rand_cc n=%0d got %h want %h", n, bus.cc_q, mdl_cc);
            end
            n_checks++;
            if ({bus.M_valid, bus.M_icode, bus.M_Cnd, bus.M_dstE, bus.M_dstM} !==
                {mdl_m.valid, mdl_m.icode, mdl_m.cnd, mdl_m.dst_e, mdl_m.dst_m}) begin
                n_errors++;
                $display("FAIL rand_mctl n=%0d got v=%b i=%h c=%b dE=%h dM=%h want v=%b i=%h c=%b dE=%h dM=%h",
                         n, bus.M_valid, bus.M_icode, bus.M_Cnd, bus.M_dstE, bus.M_dstM,
                         mdl_m.valid, mdl_m.icode, mdl_m.cnd, mdl_m.dst_e, mdl_m.dst_m);
            end
            n_checks++;
            if (bus.M_valE !== mdl_m.val_e || bus.M_valA !== mdl_m.val_a) begin
                n_errors++;
                $display("FAIL rand_mdata n=%0d got e=%h a=%h want e=%h a=%h",
                         n, bus.M_valE, bus.M_valA, mdl_m.val_e, mdl_m.val_a);
            end
        end
        rst = 0;
    endtask

    initial begin
        mdl_cc = 4'b0001;
        mdl_m  = reset_m;
        idle_inputs();
        test_reset();
        test_cc_jxx();
        test_cmov();
        test_cc_block();
        test_stall_bubble();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
